// File: rtl/term_rx_ctrl.sv
// Terminal receive controller: buffers uart_rx bytes in a small FIFO, writes
// printable characters to the character RAM at the cursor, moves the cursor
// on CR/LF/BS and a minimal ANSI CSI subset (A/B/C/D/H/2J), and sequences a
// full-screen clear while incoming bytes keep being buffered.
//
// Ports:
//   i_Clock, i_Reset_n        clock, asynchronous active-low reset
//   i_RX_DV, i_RX_Byte        one-cycle byte strobe and data from uart_rx
//   o_Wr_En/o_Wr_Addr/o_Wr_Char  character RAM write port (one cycle per write)
//   o_Cur_Col, o_Cur_Row      cursor position
//   o_Busy                    high while a screen clear is writing
//   o_Overflow                sticky: a byte was dropped on a full FIFO
module term_rx_ctrl #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 24,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Char,
  output logic [6:0]        o_Cur_Col,
  output logic [4:0]        o_Cur_Row,
  output logic              o_Busy,
  output logic              o_Overflow
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LBRK  = 8'h5B;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_ESC    = 2'd1,
    ST_CSI    = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  state_t state, state_nx;
  logic [6:0] param, param_nx;

  // Receive FIFO, pointers carry one extra wrap bit
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr, fill;
  logic           fifo_empty, fifo_full, push, pop;

  // Popped byte waiting to be interpreted
  logic [7:0] cur_byte;
  logic       cur_vld, consume;

  logic [CNT_W-1:0] clr_cnt, clr_cnt_nx;
  logic             clr_done;

  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fill == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && (state != ST_CLEAR);
  assign push       = i_RX_DV && (!fifo_full || pop);
  assign consume    = cur_vld && (state != ST_CLEAR);
  assign clr_done   = (clr_cnt == CNT_W'(CELLS));

  // FIFO storage (no reset needed on data)
  always_ff @(posedge i_Clock) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= i_RX_Byte;
  end

  // FIFO pointers, overflow flag and pop stage
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Overflow <= 1'b0;
      cur_byte   <= 8'h00;
      cur_vld    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (i_RX_DV && !push) o_Overflow <= 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + (PTR_W+1)'(1);
        cur_byte <= fifo_mem[rd_ptr[PTR_W-1:0]];
        cur_vld  <= 1'b1;
      end else if (consume) begin
        cur_vld <= 1'b0;
      end
    end
  end

  // Byte classification and parameter accumulation
  logic        is_digit, is_print;
  logic [3:0]  digit;
  logic [10:0] param_acc;
  logic [6:0]  param_dig;
  logic [6:0]  move_n;

  assign is_digit  = (cur_byte >= 8'h30) && (cur_byte <= 8'h39);
  assign is_print  = (cur_byte >= 8'h20) && (cur_byte <= 8'h7E);
  assign digit     = 4'(cur_byte - 8'h30);
  assign param_acc = 11'(param) * 11'd10 + 11'(digit);
  assign param_dig = (param_acc > 11'd99) ? 7'd99 : 7'(param_acc);
  assign move_n    = (param == 7'd0) ? 7'd1 : param;

  // Cursor arithmetic, all clamped/wrapped to the screen
  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        row_inc, row_up, row_down;
  logic [6:0]        col_left, col_right;
  logic [8:0]        col_sum, row_sum;

  assign cur_addr  = ADDR_W'(32'(o_Cur_Row) * COLS + 32'(o_Cur_Col));
  assign row_inc   = (o_Cur_Row == 5'(ROWS-1)) ? 5'd0 : o_Cur_Row + 5'd1;
  assign col_sum   = 9'(o_Cur_Col) + 9'(move_n);
  assign row_sum   = 9'(o_Cur_Row) + 9'(move_n);
  assign col_right = (col_sum > 9'(COLS-1)) ? 7'(COLS-1) : 7'(col_sum);
  assign row_down  = (row_sum > 9'(ROWS-1)) ? 5'(ROWS-1) : 5'(row_sum);
  assign col_left  = (move_n >= o_Cur_Col) ? 7'd0 : o_Cur_Col - move_n;
  assign row_up    = (9'(move_n) >= 9'(o_Cur_Row)) ? 5'd0
                                                   : 5'(9'(o_Cur_Row) - 9'(move_n));

  // State register
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= ST_GROUND;
      param <= 7'd0;
    end else begin
      state <= state_nx;
      param <= param_nx;
    end
  end

  // Next-state: parser transitions and CSI parameter
  always_comb begin
    state_nx = state;
    param_nx = param;
    if (state == ST_CLEAR) begin
      if (clr_done) state_nx = ST_GROUND;
    end else if (cur_vld) begin
      case (state)
        ST_GROUND: begin
          if (cur_byte == CH_ESC) state_nx = ST_ESC;
        end
        ST_ESC: begin
          if (cur_byte == CH_LBRK) begin
            param_nx = 7'd0;
            state_nx = ST_CSI;
          end else begin
            state_nx = ST_GROUND;
          end
        end
        ST_CSI: begin
          if (is_digit) begin
            param_nx = param_dig;
          end else if (cur_byte == "J" && param == 7'd2) begin
            state_nx = ST_CLEAR;
          end else begin
            state_nx = ST_GROUND;
          end
        end
        default: state_nx = ST_GROUND;
      endcase
    end
  end

  // Output next values: RAM write port, cursor, busy and clear counter
  logic              wr_en_nx, busy_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [7:0]        wr_char_nx;
  logic [6:0]        col_nx;
  logic [4:0]        row_nx;

  always_comb begin
    wr_en_nx   = 1'b0;
    wr_addr_nx = o_Wr_Addr;
    wr_char_nx = o_Wr_Char;
    col_nx     = o_Cur_Col;
    row_nx     = o_Cur_Row;
    busy_nx    = o_Busy;
    clr_cnt_nx = clr_cnt;
    if (state == ST_CLEAR) begin
      if (clr_done) begin
        busy_nx    = 1'b0;
        col_nx     = 7'd0;
        row_nx     = 5'd0;
        clr_cnt_nx = '0;
      end else begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = ADDR_W'(clr_cnt);
        wr_char_nx = CH_SPACE;
        busy_nx    = 1'b1;
        clr_cnt_nx = clr_cnt + CNT_W'(1);
      end
    end else if (cur_vld) begin
      case (state)
        ST_GROUND: begin
          if (is_print) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = cur_addr;
            wr_char_nx = cur_byte;
            if (o_Cur_Col == 7'(COLS-1)) begin
              col_nx = 7'd0;
              row_nx = row_inc;
            end else begin
              col_nx = o_Cur_Col + 7'd1;
            end
          end else if (cur_byte == CH_CR) begin
            col_nx = 7'd0;
          end else if (cur_byte == CH_LF) begin
            row_nx = row_inc;
          end else if (cur_byte == CH_BS) begin
            col_nx = (o_Cur_Col == 7'd0) ? 7'd0 : o_Cur_Col - 7'd1;
          end
        end
        ST_CSI: begin
          case (cur_byte)
            "A": row_nx = row_up;
            "B": row_nx = row_down;
            "C": col_nx = col_right;
            "D": col_nx = col_left;
            "H": begin
              col_nx = 7'd0;
              row_nx = 5'd0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Wr_En   <= 1'b0;
      o_Wr_Addr <= '0;
      o_Wr_Char <= 8'h00;
      o_Cur_Col <= 7'd0;
      o_Cur_Row <= 5'd0;
      o_Busy    <= 1'b0;
      clr_cnt   <= '0;
    end else begin
      o_Wr_En   <= wr_en_nx;
      o_Wr_Addr <= wr_addr_nx;
      o_Wr_Char <= wr_char_nx;
      o_Cur_Col <= col_nx;
      o_Cur_Row <= row_nx;
      o_Busy    <= busy_nx;
      clr_cnt   <= clr_cnt_nx;
    end
  end

endmodule

// File: tb/tb_term_rx_ctrl.sv
// Self-checking bench for term_rx_ctrl: expected RAM writes are queued as
// bytes are sent and compared as the DUT writes; cursor/flag state is checked
// inline by each scenario task.
module tb_term_rx_ctrl;

  localparam int CELLS = 80 * 24;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  ch;
  } wr_t;

  logic        clk, rst_n, rx_dv;
  logic [7:0]  rx_byte;
  logic        wr_en, busy, overflow;
  logic [10:0] wr_addr;
  logic [7:0]  wr_char;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  int  checks = 0;
  int  errors = 0;
  int  busy_cycles = 0;
  wr_t exp_q[$];

  term_rx_ctrl #(.COLS(80), .ROWS(24), .ADDR_W(11), .FIFO_DEPTH(16)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .i_RX_DV   (rx_dv),
    .i_RX_Byte (rx_byte),
    .o_Wr_En   (wr_en),
    .o_Wr_Addr (wr_addr),
    .o_Wr_Char (wr_char),
    .o_Cur_Col (cur_col),
    .o_Cur_Row (cur_row),
    .o_Busy    (busy),
    .o_Overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to the next falling edge and score any RAM write seen there
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (busy) busy_cycles++;
    if (rst_n && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: write addr=%0d char=%02h, expected no write", wr_addr, wr_char);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_char !== e.ch) begin
          errors++;
          $display("FAIL sb_write: got addr=%0d char=%02h, expected addr=%0d char=%02h",
                   wr_addr, wr_char, e.addr, e.ch);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic expect_wr(input int addr, input logic [7:0] ch);
    wr_t e;
    e.addr = 11'(addr);
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  task automatic esc_seq(input string s);
    send_byte(8'h1B);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_clear();
    for (int i = 0; i < CELLS; i++) expect_wr(i, 8'h20);
  endtask

  // Wait for queued writes to drain and any clear to finish, then settle
  task automatic wait_idle(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_idle: timeout, %0d writes pending busy=%0b, expected drained", exp_q.size(), busy);
    end
    repeat (4) tick();
  endtask

  task automatic wait_busy_rise();
    int n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: busy=%0b, expected 1", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({wr_en, wr_addr, wr_char, cur_col, cur_row, busy, overflow} !== 34'd0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h, expected 0", {wr_en, wr_addr, wr_char, cur_col, cur_row, busy, overflow});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({wr_en, wr_addr, wr_char, cur_col, cur_row, busy, overflow} !== 34'd0) begin
      errors++;
      $display("FAIL reset_idle: outputs=%h, expected 0", {wr_en, wr_addr, wr_char, cur_col, cur_row, busy, overflow});
    end
  endtask

  task automatic test_hi();
    expect_wr(0, "H");
    send_byte("H");
    expect_wr(1, "i");
    send_byte("i");
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL hi_latency_early: wr_en=%0b one cycle after first byte, expected 0", wr_en);
    end
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_char !== "H") begin
      errors++;
      $display("FAIL hi_latency: wr_en=%0b addr=%0d char=%02h, expected 1/0/48", wr_en, wr_addr, wr_char);
    end
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd2 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL hi_cursor: (%0d,%0d), expected (2,0)", cur_col, cur_row);
    end
  endtask

  task automatic test_controls();
    send_byte(8'h08);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h08);
    send_byte(8'h7F);
    send_byte(8'h01);
    send_byte(8'h80);
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd1) begin
      errors++;
      $display("FAIL ctrl_cursor: (%0d,%0d), expected (0,1)", cur_col, cur_row);
    end
    expect_wr(80, "c");
    send_byte("c");
    send_byte(8'h08);
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd1) begin
      errors++;
      $display("FAIL ctrl_bs: (%0d,%0d), expected (0,1)", cur_col, cur_row);
    end
  endtask

  task automatic test_csi();
    esc_seq("[H");
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL csi_home: (%0d,%0d), expected (0,0)", cur_col, cur_row);
    end
    esc_seq("[5C");
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd5 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL csi_right: (%0d,%0d), expected (5,0)", cur_col, cur_row);
    end
    esc_seq("[99D");
    esc_seq("[A");
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL csi_clamp_lu: (%0d,%0d), expected (0,0)", cur_col, cur_row);
    end
    esc_seq("[3B");
    esc_seq("[0C");
    esc_seq("[1J");
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd1 || cur_row !== 5'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL csi_down_p0: (%0d,%0d) busy=%0b, expected (1,3) busy=0", cur_col, cur_row, busy);
    end
    esc_seq("[H");
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL csi_home2: (%0d,%0d), expected (0,0)", cur_col, cur_row);
    end
  endtask

  task automatic test_wrap();
    esc_seq("[99C");
    esc_seq("[99B");
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd79 || cur_row !== 5'd23) begin
      errors++;
      $display("FAIL wrap_clamp: (%0d,%0d), expected (79,23)", cur_col, cur_row);
    end
    expect_wr(1919, "X");
    send_byte("X");
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL wrap_char: (%0d,%0d), expected (0,0)", cur_col, cur_row);
    end
    esc_seq("[99B");
    send_byte(8'h0A);
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL wrap_lf: (%0d,%0d), expected (0,0)", cur_col, cur_row);
    end
  endtask

  task automatic test_clear();
    int b0;
    int n = 0;
    esc_seq("[3B");
    esc_seq("[5C");
    wait_idle(50);
    b0 = busy_cycles;
    expect_clear();
    esc_seq("[2J");
    wait_busy_rise();
    checks++;
    if (cur_col !== 7'd5 || cur_row !== 5'd3) begin
      errors++;
      $display("FAIL clear_hold_cursor: (%0d,%0d), expected (5,3)", cur_col, cur_row);
    end
    expect_wr(0, "A");
    send_byte("A");
    expect_wr(1, "B");
    send_byte("B");
    while (busy && n < 2500) begin
      tick();
      n++;
    end
    checks++;
    if (busy_cycles - b0 != CELLS) begin
      errors++;
      $display("FAIL clear_busy_len: %0d busy cycles, expected %0d", busy_cycles - b0, CELLS);
    end
    checks++;
    if (busy !== 1'b0 || cur_col !== 7'd0 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL clear_end: busy=%0b (%0d,%0d), expected busy=0 (0,0)", busy, cur_col, cur_row);
    end
    wait_idle(100);
    checks++;
    if (cur_col !== 7'd2 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL clear_ab_cursor: (%0d,%0d), expected (2,0)", cur_col, cur_row);
    end
  endtask

  task automatic test_overflow();
    expect_clear();
    esc_seq("[2J");
    wait_busy_rise();
    for (int i = 0; i < 16; i++) begin
      expect_wr(i, 8'(8'h61 + i));
      send_byte(8'(8'h61 + i));
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: overflow=%0b after 16 bytes, expected 0", overflow);
    end
    send_byte("q");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: overflow=%0b after 17 bytes, expected 1", overflow);
    end
    wait_idle(2500);
    checks++;
    if (overflow !== 1'b1 || cur_col !== 7'd16 || cur_row !== 5'd0) begin
      errors++;
      $display("FAIL ovf_after: overflow=%0b (%0d,%0d), expected 1 (16,0)", overflow, cur_col, cur_row);
    end
  endtask

  task automatic test_reset_mid_clear();
    expect_clear();
    esc_seq("[2J");
    wait_busy_rise();
    repeat (50) tick();
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_char, cur_col, cur_row, busy, overflow} !== 34'd0) begin
      errors++;
      $display("FAIL rst_mid_clear: outputs=%h, expected 0", {wr_en, wr_addr, wr_char, cur_col, cur_row, busy, overflow});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_resume: busy=%0b wr_en=%0b, expected 0/0", busy, wr_en);
    end
    expect_wr(0, "Z");
    send_byte("Z");
    wait_idle(50);
    checks++;
    if (cur_col !== 7'd1 || cur_row !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_z: (%0d,%0d) overflow=%0b, expected (1,0) 0", cur_col, cur_row, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_hi();
    test_controls();
    test_csi();
    test_wrap();
    test_clear();
    test_overflow();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
